// File: rtl/sprite_mover.sv
// Pixel stage after the VGA timing controller: draws a bouncing square sprite
// and re-times the syncs so they leave on the same pixel as the colour.
module sprite_mover #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          SIZE        = 32,
    parameter int          STEP        = 2,
    parameter int          START_X     = 100,
    parameter int          START_Y     = 60,
    parameter logic [7:0]  FG          = 8'hE0,
    parameter logic [7:0]  BG          = 8'h03,
    parameter logic [7:0]  BOUNCE_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       bright,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       freeze,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [1:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [7:0] bounce_cnt
);

    localparam logic [10:0] L_H       = 11'(H_ACTIVE);
    localparam logic [10:0] L_V       = 11'(V_ACTIVE);
    localparam logic [10:0] L_SIZE    = 11'(SIZE);
    localparam logic [10:0] L_STEP    = 11'(STEP);
    localparam logic [10:0] L_START_X = 11'(START_X);
    localparam logic [10:0] L_START_Y = 11'(START_Y);

    typedef struct packed {
        logic [10:0] pos;
        logic        dir_neg;
        logic        bounce;
    } axis_t;

    // One axis of motion; 11-bit math keeps pos+SIZE+STEP from wrapping.
    function automatic axis_t axis_next(input logic [10:0] pos,
                                        input logic        dir_neg,
                                        input logic [10:0] limit);
        axis_t res;
        // NOTE: every field gets a default before the branches, so no path leaves a stale value (no latch).
        res.pos     = pos;
        res.dir_neg = dir_neg;
        res.bounce  = 1'b0;
        if (!dir_neg) begin
            if (pos + L_SIZE + L_STEP > limit) begin
                res.pos     = limit - L_SIZE;
                res.dir_neg = 1'b1;
                res.bounce  = 1'b1;
            end else begin
                res.pos = pos + L_STEP;
            end
        end else begin
            if (pos < L_STEP) begin
                res.pos     = '0;
                res.dir_neg = 1'b0;
                res.bounce  = 1'b1;
            end else begin
                res.pos = pos - L_STEP;
            end
        end
        return res;
    endfunction

    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_dx_neg;
    logic        r_dy_neg;
    logic [7:0]  r_bounce_cnt;
    logic        r_frame_tick;

    logic        r_inside;
    logic        r_bright_d;
    logic        r_hs_d;
    logic        r_vs_d;
    logic [7:0]  r_rgb;
    logic        r_hs;
    logic        r_vs;

    axis_t       w_x_nxt;
    axis_t       w_y_nxt;
    logic        w_tick;
    logic        w_update;
    logic [7:0]  w_bounce_inc;
    logic [10:0] w_hc;
    logic [10:0] w_vc;
    logic        w_inside;
    logic [7:0]  w_colour;

    assign w_hc = {1'b0, hcount};
    assign w_vc = {1'b0, vcount};

    // The update point is the first pixel of the first blanking line.
    assign w_tick   = pix_en && (hcount == 10'd0) && (w_vc == L_V);
    assign w_update = w_tick && !freeze;

    assign w_x_nxt      = axis_next(r_x, r_dx_neg, L_H);
    assign w_y_nxt      = axis_next(r_y, r_dy_neg, L_V);
    assign w_bounce_inc = {7'd0, w_x_nxt.bounce} + {7'd0, w_y_nxt.bounce};

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x          <= L_START_X;
            r_y          <= L_START_Y;
            r_dx_neg     <= 1'b0;
            r_dy_neg     <= 1'b0;
            r_bounce_cnt <= BOUNCE_INIT;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_tick;
            if (w_update) begin
                r_x          <= w_x_nxt.pos;
                r_y          <= w_y_nxt.pos;
                r_dx_neg     <= w_x_nxt.dir_neg;
                r_dy_neg     <= w_y_nxt.dir_neg;
                r_bounce_cnt <= r_bounce_cnt + w_bounce_inc;
            end
        end
    end

    assign w_inside = (w_hc >= r_x) && (w_hc < r_x + L_SIZE) &&
                      (w_vc >= r_y) && (w_vc < r_y + L_SIZE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inside   <= 1'b0;
            r_bright_d <= 1'b0;
            r_hs_d     <= 1'b1;
            r_vs_d     <= 1'b1;
        end else if (pix_en) begin
            r_inside   <= w_inside;
            r_bright_d <= bright;
            r_hs_d     <= hsync_in;
            r_vs_d     <= vsync_in;
        end
    end

    assign w_colour = r_bright_d ? (r_inside ? FG : BG) : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb <= 8'h00;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else if (pix_en) begin
            r_rgb <= w_colour;
            r_hs  <= r_hs_d;
            r_vs  <= r_vs_d;
        end
    end

    assign r          = r_rgb[7:5];
    assign g          = r_rgb[4:2];
    assign b          = r_rgb[1:0];
    assign hsync      = r_hs;
    assign vsync      = r_vs;
    assign frame_tick = r_frame_tick;
    assign bounce_cnt = r_bounce_cnt;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: default instance plus wall/corner/wrap variants.
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       bright;
    logic       hsync_in;
    logic       vsync_in;
    logic       freeze_a;
    logic       freeze_e;

    logic [2:0] r_a, g_a, r_b, g_b, r_c, g_c, r_w, g_w;
    logic [1:0] b_a, b_b, b_c, b_w;
    logic       hs_a, vs_a, ft_a, hs_b, vs_b, ft_b, hs_c, vs_c, ft_c, hs_w, vs_w, ft_w;
    logic [7:0] bc_a, bc_b, bc_c, bc_w;
    logic [7:0] rgb_a, rgb_c;

    int n_checks = 0;
    int n_pass   = 0;

    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_c = {r_c, g_c, b_c};

    always #5 clk = ~clk;

    sprite_mover dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .bright(bright), .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze_a),
        .r(r_a), .g(g_a), .b(b_a), .hsync(hs_a), .vsync(vs_a),
        .frame_tick(ft_a), .bounce_cnt(bc_a)
    );

    sprite_mover #(.START_X(607)) dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .bright(bright), .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze_e),
        .r(r_b), .g(g_b), .b(b_b), .hsync(hs_b), .vsync(vs_b),
        .frame_tick(ft_b), .bounce_cnt(bc_b)
    );

    sprite_mover #(.START_X(607), .START_Y(447)) dut_c (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .bright(bright), .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze_e),
        .r(r_c), .g(g_c), .b(b_c), .hsync(hs_c), .vsync(vs_c),
        .frame_tick(ft_c), .bounce_cnt(bc_c)
    );

    sprite_mover #(.START_X(607), .START_Y(447), .BOUNCE_INIT(8'd255)) dut_w (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .bright(bright), .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze_e),
        .r(r_w), .g(g_w), .b(b_w), .hsync(hs_w), .vsync(vs_w),
        .frame_tick(ft_w), .bounce_cnt(bc_w)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One update-point cycle, then park the counters on a later blanking pixel.
    task automatic frame_tick_cycle();
        pix_en = 1'b1;
        hcount = 10'd0;
        vcount = 10'd480;
        step(1);
        hcount = 10'd5;
        vcount = 10'd481;
    endtask

    task automatic test_reset();
        rst = 1'b0; pix_en = 1'b0; hcount = 10'd0; vcount = 10'd0; bright = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; freeze_a = 1'b0; freeze_e = 1'b1;
        #12;
        n_checks++; if (rgb_a !== 8'h00) $display("FAIL reset_rgb: got %h want 00", rgb_a); else n_pass++;
        n_checks++; if (hs_a !== 1'b1) $display("FAIL reset_hsync: got %b want 1", hs_a); else n_pass++;
        n_checks++; if (vs_a !== 1'b1) $display("FAIL reset_vsync: got %b want 1", vs_a); else n_pass++;
        n_checks++; if (ft_a !== 1'b0) $display("FAIL reset_tick: got %b want 0", ft_a); else n_pass++;
        n_checks++; if (bc_a !== 8'd0) $display("FAIL reset_bounce: got %0d want 0", bc_a); else n_pass++;
        n_checks++; if (dut_a.r_x !== 11'd100) $display("FAIL reset_x: got %0d want 100", dut_a.r_x); else n_pass++;
        n_checks++; if (dut_a.r_y !== 11'd60) $display("FAIL reset_y: got %0d want 60", dut_a.r_y); else n_pass++;
        n_checks++; if (bc_w !== 8'd255) $display("FAIL reset_bounce_preset: got %0d want 255", bc_w); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_pixel();
        logic [9:0] tv_h [7];
        logic [9:0] tv_v [7];
        logic       tv_br[7];
        logic [7:0] tv_rgb[7];
        tv_h = '{10'd99, 10'd131, 10'd132, 10'd100, 10'd100, 10'd100, 10'd100};
        tv_v = '{10'd60, 10'd60,  10'd60,  10'd91,  10'd92,  10'd59,  10'd60};
        tv_br = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tv_rgb = '{8'h03, 8'hE0, 8'h03, 8'hE0, 8'h03, 8'h03, 8'h00};
        pix_en = 1'b1; hcount = 10'd100; vcount = 10'd60; bright = 1'b1;
        step(1);
        n_checks++; if (rgb_a !== 8'h00) $display("FAIL pix_latency1: got %h want 00", rgb_a); else n_pass++;
        step(1);
        n_checks++; if (rgb_a !== 8'hE0) $display("FAIL pix_corner: got %h want e0", rgb_a); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            hcount = tv_h[i]; vcount = tv_v[i]; bright = tv_br[i];
            step(2);
            n_checks++;
            if (rgb_a !== tv_rgb[i])
                $display("FAIL pix_vec%0d (h=%0d v=%0d br=%b): got %h want %h",
                         i, tv_h[i], tv_v[i], tv_br[i], rgb_a, tv_rgb[i]);
            else n_pass++;
        end
    endtask

    task automatic test_sync_pipe();
        logic [5:0] h_pat = 6'b010110;
        logic [5:0] v_pat = 6'b011001;
        logic       exp_h;
        logic       exp_v;
        for (int k = 0; k < 6; k++) begin
            exp_h = (k == 0) ? 1'b1 : h_pat[k-1];
            exp_v = (k == 0) ? 1'b1 : v_pat[k-1];
            pix_en = 1'b1; hsync_in = h_pat[k]; vsync_in = v_pat[k];
            step(1);
            n_checks++; if (hs_a !== exp_h) $display("FAIL sync_h_pulse%0d: got %b want %b", k, hs_a, exp_h); else n_pass++;
            n_checks++; if (vs_a !== exp_v) $display("FAIL sync_v_pulse%0d: got %b want %b", k, vs_a, exp_v); else n_pass++;
            pix_en = 1'b0; hsync_in = ~h_pat[k]; vsync_in = ~v_pat[k];
            step(1);
            n_checks++; if (hs_a !== exp_h) $display("FAIL sync_h_hold%0d: got %b want %b", k, hs_a, exp_h); else n_pass++;
            n_checks++; if (vs_a !== exp_v) $display("FAIL sync_v_hold%0d: got %b want %b", k, vs_a, exp_v); else n_pass++;
        end
        pix_en = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        step(2);
    endtask

    task automatic test_frame_ticks();
        freeze_a = 1'b0;
        for (int t = 0; t < 5; t++) begin
            frame_tick_cycle();
            n_checks++; if (ft_a !== 1'b1) $display("FAIL tick_high%0d: got %b want 1", t, ft_a); else n_pass++;
            step(1);
            n_checks++; if (ft_a !== 1'b0) $display("FAIL tick_low%0d: got %b want 0", t, ft_a); else n_pass++;
        end
        n_checks++; if (dut_a.r_x !== 11'd110) $display("FAIL tick5_x: got %0d want 110", dut_a.r_x); else n_pass++;
        n_checks++; if (dut_a.r_y !== 11'd70) $display("FAIL tick5_y: got %0d want 70", dut_a.r_y); else n_pass++;
        n_checks++; if (bc_a !== 8'd0) $display("FAIL tick5_bounce: got %0d want 0", bc_a); else n_pass++;
    endtask

    task automatic test_walls();
        logic [9:0] tv_h [4];
        logic [7:0] tv_rgb[4];
        tv_h = '{10'd606, 10'd605, 10'd637, 10'd638};
        tv_rgb = '{8'hE0, 8'h03, 8'hE0, 8'h03};
        freeze_a = 1'b1; freeze_e = 1'b0;
        frame_tick_cycle();
        n_checks++; if (dut_b.r_x !== 11'd608) $display("FAIL wall_x1: got %0d want 608", dut_b.r_x); else n_pass++;
        n_checks++; if (dut_b.r_dx_neg !== 1'b1) $display("FAIL wall_dx1: got %b want 1", dut_b.r_dx_neg); else n_pass++;
        n_checks++; if (bc_b !== 8'd1) $display("FAIL wall_bounce1: got %0d want 1", bc_b); else n_pass++;
        n_checks++; if (dut_b.r_y !== 11'd62) $display("FAIL wall_y1: got %0d want 62", dut_b.r_y); else n_pass++;
        n_checks++; if (dut_c.r_x !== 11'd608) $display("FAIL corner_x: got %0d want 608", dut_c.r_x); else n_pass++;
        n_checks++; if (dut_c.r_y !== 11'd448) $display("FAIL corner_y: got %0d want 448", dut_c.r_y); else n_pass++;
        n_checks++; if (bc_c !== 8'd2) $display("FAIL corner_bounce: got %0d want 2", bc_c); else n_pass++;
        n_checks++; if (bc_w !== 8'd1) $display("FAIL corner_wrap: got %0d want 1", bc_w); else n_pass++;
        step(1);
        frame_tick_cycle();
        n_checks++; if (dut_b.r_x !== 11'd606) $display("FAIL wall_x2: got %0d want 606", dut_b.r_x); else n_pass++;
        n_checks++; if (bc_b !== 8'd1) $display("FAIL wall_bounce2: got %0d want 1", bc_b); else n_pass++;
        n_checks++; if (dut_c.r_y !== 11'd446) $display("FAIL corner_y2: got %0d want 446", dut_c.r_y); else n_pass++;
        freeze_e = 1'b1;
        bright = 1'b1; vcount = 10'd446;
        for (int i = 0; i < 4; i++) begin
            hcount = tv_h[i];
            step(2);
            n_checks++;
            if (rgb_c !== tv_rgb[i]) $display("FAIL corner_pix%0d (h=%0d): got %h want %h", i, tv_h[i], rgb_c, tv_rgb[i]);
            else n_pass++;
        end
    endtask

    task automatic test_freeze();
        freeze_a = 1'b1;
        for (int t = 0; t < 3; t++) begin
            frame_tick_cycle();
            n_checks++; if (ft_a !== 1'b1) $display("FAIL frz_tick%0d: got %b want 1", t, ft_a); else n_pass++;
            n_checks++; if (dut_a.r_x !== 11'd110 || dut_a.r_y !== 11'd70)
                $display("FAIL frz_pos%0d: got (%0d,%0d) want (110,70)", t, dut_a.r_x, dut_a.r_y);
            else n_pass++;
            step(1);
        end
        freeze_a = 1'b0;
        frame_tick_cycle();
        n_checks++; if (dut_a.r_x !== 11'd112 || dut_a.r_y !== 11'd72)
            $display("FAIL unfrz_pos: got (%0d,%0d) want (112,72)", dut_a.r_x, dut_a.r_y);
        else n_pass++;
        pix_en = 1'b0; hcount = 10'd0; vcount = 10'd480;
        step(1);
        n_checks++; if (ft_a !== 1'b0) $display("FAIL noen_tick: got %b want 0", ft_a); else n_pass++;
        n_checks++; if (dut_a.r_x !== 11'd112) $display("FAIL noen_x: got %0d want 112", dut_a.r_x); else n_pass++;
        hcount = 10'd5; vcount = 10'd481;
        pix_en = 1'b1;
        step(1);
    endtask

    task automatic test_async_reset();
        hcount = 10'd112; vcount = 10'd72; bright = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        step(2);
        n_checks++; if (rgb_a !== 8'hE0) $display("FAIL prerst_rgb: got %h want e0", rgb_a); else n_pass++;
        n_checks++; if (hs_a !== 1'b0) $display("FAIL prerst_hsync: got %b want 0", hs_a); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (rgb_a !== 8'h00) $display("FAIL arst_rgb: got %h want 00", rgb_a); else n_pass++;
        n_checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1) $display("FAIL arst_sync: got %b%b want 11", hs_a, vs_a); else n_pass++;
        n_checks++; if (bc_b !== 8'd0) $display("FAIL arst_bounce: got %0d want 0", bc_b); else n_pass++;
        n_checks++; if (dut_a.r_x !== 11'd100 || dut_a.r_y !== 11'd60)
            $display("FAIL arst_pos: got (%0d,%0d) want (100,60)", dut_a.r_x, dut_a.r_y);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        frame_tick_cycle();
        n_checks++; if (dut_a.r_x !== 11'd102 || dut_a.r_y !== 11'd62)
            $display("FAIL postrst_pos: got (%0d,%0d) want (102,62)", dut_a.r_x, dut_a.r_y);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_sync_pipe();
        test_frame_ticks();
        test_walls();
        test_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
